led_strip_frame_sequencer: RTL and testbench

Sequences one complete refresh of an APA102-style serial LED strip, such as the 8x8 snake-wired matrix.
- Transmission order: 32-bit zero start frame, NUM_LEDS 32-bit LED frames, a zero end frame, then an inter-frame gap.
- Pixel colours are pulled from an upstream pixel source (font renderer, frame buffer) over a valid/ready handshake, indexed by LED position.
- Drives the strip's clock and data pins directly, so upstream blocks no longer need to count bits.

---
 rtl/led_strip_frame_sequencer_if.sv | 27 ++
 rtl/led_strip_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_led_strip_frame_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_strip_frame_sequencer_if.sv
// Pixel request channel between an upstream pixel source and the strip sequencer.
// The sequencer names the LED it wants on led_index and raises pix_ready; the
// source answers with pix_data/pix_valid for that LED.
interface led_strip_frame_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             pix_valid;
    logic [23:0]      pix_data;
    logic             pix_ready;
    logic [IDX_W-1:0] led_index;

    // Pixel source side: supplies colours for the requested index.
    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  led_index
    );

    // Sequencer side: requests colours by LED index.
    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output led_index
    );
endinterface

// File: rtl/led_strip_frame_sequencer.sv
// One APA102-style strip refresh: 32-bit zero start frame, one 32-bit word per
// LED pulled from the pixel source, END_BITS zero bits, then an idle gap.
// sclk/sdata drive the strip pins directly; bits go out MSB first with sdata
// changing while sclk is low so the strip samples on the rising edge.
module led_strip_frame_sequencer #(
    parameter int NUM_LEDS   = 64,
    parameter int CLK_DIV    = 1,
    parameter int END_BITS   = 64,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [4:0]                 brightness,
    led_strip_frame_sequencer_if.slave pix,
    output logic                       busy,
    output logic                       done,
    output logic                       sclk,
    output logic                       sdata
);
    localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PH_W     = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
    localparam int MAX_BITS = (END_BITS > 32) ? END_BITS : 32;
    localparam int BIT_W    = $clog2(MAX_BITS);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(31);
    localparam logic [BIT_W-1:0] END_LAST  = BIT_W'(END_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_LED,
        S_END,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q;      // position inside the current bit
    logic [BIT_W-1:0] bit_q;        // bit number inside the current frame
    logic [GAP_W-1:0] gap_q;        // idle cycles spent in the gap
    logic [31:0]      shift_q;      // LED word being shifted out
    logic [4:0]       bright_q;     // brightness captured for this refresh
    logic [IDX_W-1:0] led_index_q;

    logic shifting;
    logic bit_end;
    logic handshake;
    logic idx_last;
    logic gap_end;

    assign shifting  = (state_q == S_START) || (state_q == S_LED) || (state_q == S_END);
    assign bit_end   = shifting && (phase_q == PH_LAST);
    assign handshake = (state_q == S_FETCH) && pix.pix_valid;
    assign idx_last  = (led_index_q == IDX_LAST);
    assign gap_end   = (state_q == S_GAP) && (gap_q == GAP_LAST);

    assign pix.led_index = led_index_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: frames advance on the last cycle of their last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_START;
            S_START: if (bit_end && bit_q == WORD_LAST) state_d = S_FETCH;
            S_FETCH: if (handshake) state_d = S_LED;
            S_LED:   if (bit_end && bit_q == WORD_LAST) state_d = idx_last ? S_END : S_FETCH;
            S_END:   if (bit_end && bit_q == END_LAST) state_d = S_GAP;
            S_GAP:   if (gap_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin and status decode; sclk is high in the second half of every bit.
    always_comb begin
        sclk          = 1'b0;
        sdata         = 1'b0;
        done          = 1'b0;
        pix.pix_ready = 1'b0;
        case (state_q)
            S_START, S_END: sclk = (phase_q >= PH_HIGH);
            S_LED: begin
                sclk  = (phase_q >= PH_HIGH);
                sdata = shift_q[31];
            end
            S_FETCH: pix.pix_ready = 1'b1;
            S_GAP:   done = gap_end;
            default: ;
        endcase
        busy = (state_q != S_IDLE) && !done;
    end

    // Bit timing counters, shift register, latched brightness and LED index.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            bright_q    <= '0;
            led_index_q <= '0;
        end else begin
            phase_q <= (shifting && !bit_end) ? phase_q + 1'b1 : '0;

            if (state_d != state_q) begin
                bit_q <= '0;
            end else if (bit_end) begin
                bit_q <= bit_q + 1'b1;
            end

            gap_q <= ((state_q == S_GAP) && !gap_end) ? gap_q + 1'b1 : '0;

            if (state_q == S_IDLE && start) begin
                bright_q <= brightness;
            end

            if (handshake) begin
                shift_q <= {3'b111, bright_q, pix.pix_data};
            end else if (state_q == S_LED && bit_end) begin
                shift_q <= {shift_q[30:0], 1'b0};
            end

            if (state_q == S_IDLE && start) begin
                led_index_q <= '0;
            end else if (state_q == S_LED && bit_end && bit_q == WORD_LAST && !idx_last) begin
                led_index_q <= led_index_q + 1'b1;
            end else if (gap_end) begin
                led_index_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_led_strip_frame_sequencer.sv
// Bench for led_strip_frame_sequencer: a bit-stream model (queue of expected
// bits per refresh) checked on every negative clock edge, plus directed
// scenarios with hand-computed literal expectations.
module tb_led_strip_frame_sequencer;
    localparam int NUM_LEDS    = 2;
    localparam int CLK_DIV     = 1;
    localparam int END_BITS    = 64;
    localparam int GAP_CYCLES  = 4;
    localparam int IDX_W       = 1;
    localparam int FRAME_RISES = 32 + 32 * NUM_LEDS + END_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] brightness = 5'h00;
    logic       busy, done, sclk, sdata;

    led_strip_frame_sequencer_if #(.IDX_W(IDX_W)) pif ();

    led_strip_frame_sequencer #(
        .NUM_LEDS  (NUM_LEDS),
        .CLK_DIV   (CLK_DIV),
        .END_BITS  (END_BITS),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .brightness(brightness),
        .pix       (pif),
        .busy      (busy),
        .done      (done),
        .sclk      (sclk),
        .sdata     (sdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [4:0] bri, input logic [23:0] pix);
        return {3'b111, bri, pix};
    endfunction

    // Pixel source memory, indexed by LED position.
    logic [23:0] pix_mem [NUM_LEDS];

    // ---------------- model state ----------------
    bit          m_rst_in   = 1'b1;
    bit          m_start_in = 1'b0;
    logic [4:0]  m_bri_in   = 5'h00;
    bit          m_active   = 1'b0;
    int          m_first_rise;
    int          m_done_cyc = -1;
    bit          m_bits[$];
    int          m_leds[$];        // LED number per bit; -1 start frame, -2 end frame
    bit          prev_sclk = 1'b0;
    bit          exp_bit;
    int          exp_led;
    bit          exp_done;
    logic [31:0] w;

    // Observations shared with the directed stimulus.
    int          rise_cnt = 0;
    int          first_rise_cyc = -1;
    int          last_rise_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] led_word [NUM_LEDS];
    logic [31:0] start_word;

    // Model update and per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_rst_in) begin
            m_active = 1'b0;
            m_bits.delete();
            m_leds.delete();
            m_done_cyc = -1;
        end else if (m_active) begin
            if (m_done_cyc >= 0 && cyc - 1 == m_done_cyc) m_active = 1'b0;
        end else if (m_start_in) begin
            m_active       = 1'b1;
            m_done_cyc     = -1;
            m_first_rise   = cyc + CLK_DIV;
            rise_cnt       = 0;
            first_rise_cyc = -1;
            start_word     = '1;
            for (int b = 0; b < 32; b++) begin
                m_bits.push_back(1'b0);
                m_leds.push_back(-1);
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                w = model_word(m_bri_in, pix_mem[i]);
                led_word[i] = 'x;
                for (int b = 31; b >= 0; b--) begin
                    m_bits.push_back(w[b]);
                    m_leds.push_back(i);
                end
            end
            for (int b = 0; b < END_BITS; b++) begin
                m_bits.push_back(1'b0);
                m_leds.push_back(-2);
            end
        end

        exp_done = m_active && (cyc == m_done_cyc);
        chk("done", done, exp_done);
        chk("busy", busy, m_active && !exp_done);

        if (!m_active) begin
            chk("idle_sclk", sclk, 0);
            chk("idle_sdata", sdata, 0);
            chk("idle_pix_ready", pif.pix_ready, 0);
            chk("idle_led_index", pif.led_index, 0);
        end else if (sclk && !prev_sclk) begin
            if (m_bits.size() == 0) begin
                chk("sclk_edge_count", rise_cnt + 1, FRAME_RISES);
            end else begin
                exp_bit = m_bits.pop_front();
                exp_led = m_leds.pop_front();
                chk("sdata_bit", sdata, exp_bit);
                if (rise_cnt == 0) begin
                    chk("first_edge_cycle", cyc, m_first_rise);
                    first_rise_cyc = cyc;
                end
                if (exp_led >= 0) begin
                    chk("led_index_shift", pif.led_index, exp_led);
                    led_word[exp_led] = {led_word[exp_led][30:0], sdata};
                end else if (exp_led == -1) begin
                    start_word = {start_word[30:0], sdata};
                end
                rise_cnt++;
                last_rise_cyc = cyc;
                if (m_bits.size() == 0) m_done_cyc = cyc + GAP_CYCLES;
            end
        end else if (pif.pix_ready) begin
            chk("fetch_sclk", sclk, 0);
            chk("fetch_sdata", sdata, 0);
            if (m_leds.size() > 0) chk("fetch_index", pif.led_index, m_leds[0]);
            else chk("pix_ready_after_frames", pif.pix_ready, 0);
        end else if (m_bits.size() == 0) begin
            chk("gap_sclk", sclk, 0);
            chk("gap_sdata", sdata, 0);
        end

        if (done === 1'b1) done_cnt++;
        prev_sclk  = sclk;
        m_rst_in   = reset;
        m_start_in = start;
        m_bri_in   = brightness;
    end

    // Pixel source: answers whatever index the sequencer is requesting.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pif.pix_data = pix_mem[pif.led_index];
        end
    end

    // ---------------- directed stimulus ----------------
    int s_cyc;
    int d0;
    int d_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (rise_cnt < n && k < budget) begin
            step();
            k++;
        end
        chk("edge_wait", (rise_cnt >= n) ? n : rise_cnt, n);
    endtask

    task automatic wait_done(input int budget);
        int d = done_cnt;
        int k = 0;
        while (done_cnt == d && k < budget) begin
            step();
            k++;
        end
        chk("done_wait", done_cnt - d, 1);
    endtask

    task automatic wait_cycle(input int target, input int budget);
        int k = 0;
        while (cyc < target && k < budget) begin
            step();
            k++;
        end
        chk("reach_cycle", cyc, target);
    endtask

    initial begin
        pif.pix_valid = 1'b0;
        pif.pix_data  = '0;
        pix_mem[0]    = 24'h0000FF;
        pix_mem[1]    = 24'h123456;

        // Reset held for three cycles.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sclk", sclk, 0);
            chk("rst_sdata", sdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pix_ready", pif.pix_ready, 0);
            chk("rst_led_index", pif.led_index, 0);
        end
        reset = 1'b0;
        step();

        // Full frame with pix_valid tied high.
        brightness    = 5'h1F;
        pif.pix_valid = 1'b1;
        chk("model_word_pin", model_word(brightness, pix_mem[0]), 32'hFF0000FF);
        d0 = done_cnt;
        pulse_start();
        wait_rises(FRAME_RISES, 2000);
        d_cyc = last_rise_cyc + GAP_CYCLES;
        wait_cycle(d_cyc, 50);
        chk("t1_done_pulse", done, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_no_early_done", done_cnt - d0, 0);
        chk("t1_edges", rise_cnt, 160);
        chk("t1_first_edge_delay", first_rise_cyc - s_cyc, 2);
        chk("t1_led0_word", led_word[0], 32'hFF0000FF);
        chk("t1_led1_word", led_word[1], 32'hFF123456);
        chk("t1_start_frame", start_word, 32'h0);

        // start in the done cycle is dropped; start one cycle later is taken.
        pix_mem[1] = 24'hA5C33C;
        start = 1'b1;
        step();
        chk("t1_done_once", done_cnt - d0, 1);
        chk("start_on_done_dropped", busy, 0);
        chk("done_single_cycle", done, 0);
        d0    = done_cnt;
        s_cyc = cyc;
        step();
        start = 1'b0;
        chk("start_after_done_taken", busy, 1);
        step();

        // Dropped start plus brightness change during LED 0.
        wait_rises(40, 500);
        start      = 1'b1;
        brightness = 5'h00;
        step();
        start = 1'b0;
        chk("dropped_start_busy", busy, 1);

        // Stall in FETCH for LED 1.
        wait_rises(64, 500);
        pif.pix_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_pix_ready", pif.pix_ready, 1);
            chk("stall_sclk", sclk, 0);
            chk("stall_led_index", pif.led_index, 1);
            if (i == 9) pif.pix_valid = 1'b1;
            step();
        end
        chk("stall_release_ready", pif.pix_ready, 0);
        chk("stall_release_msb", sdata, 1);
        wait_done(2000);
        step();
        step();
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_led1_word", led_word[1], 32'hFFA5C33C);
        chk("t2_edges", rise_cnt, 160);

        // Reset during the 5th bit of LED 0, then a clean refresh.
        brightness = 5'h1F;
        step();
        pulse_start();
        wait_rises(36, 500);
        reset = 1'b1;
        step();
        chk("midrst_sclk", sclk, 0);
        chk("midrst_sdata", sdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_led_index", pif.led_index, 0);
        reset = 1'b0;
        step();
        d0 = done_cnt;
        pulse_start();
        wait_done(2000);
        chk("t3_done_once", done_cnt - d0, 1);
        chk("t3_edges", rise_cnt, 160);
        chk("t3_first_edge_delay", first_rise_cyc - s_cyc, 2);
        chk("t3_start_frame", start_word, 32'h0);
        chk("t3_led0_word", led_word[0], 32'hFF0000FF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
